// File: rtl/scr1_pipe_mprf_dbgacc.sv
// Debug access port to the multi-port register file (MPRF).
// Serves single-beat GPR writes and multi-beat GPR reads from the debug
// module while the hart is halted. Every command produces at least one
// response beat; illegal commands produce a single error beat.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new command
// READ  | MPRF read port driven with the current address for one cycle
// WRITE | MPRF write port driven from the latched command for one cycle
// RSP   | response beat presented, held until the debugger accepts it
// ERR   | one-cycle bubble before an error response, no MPRF access

module scr1_pipe_mprf_dbgacc #(
  parameter int MPRF_ADDR_WIDTH = 5,
  parameter int XLEN            = 32,
  parameter bit RVE_EN          = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dbg2acc_cmd_vld,
  output logic                       acc2dbg_cmd_rdy,
  input  logic                       dbg2acc_cmd_we,
  input  logic [MPRF_ADDR_WIDTH-1:0] dbg2acc_cmd_addr,
  input  logic [MPRF_ADDR_WIDTH-1:0] dbg2acc_cmd_cnt,
  input  logic [XLEN-1:0]            dbg2acc_cmd_wdata,
  output logic                       acc2dbg_rsp_vld,
  input  logic                       dbg2acc_rsp_rdy,
  output logic [XLEN-1:0]            acc2dbg_rsp_data,
  output logic                       acc2dbg_rsp_err,
  output logic                       acc2dbg_rsp_last,
  input  logic                       hart_halted,
  output logic [MPRF_ADDR_WIDTH-1:0] acc2mprf_rs1_addr,
  input  logic [XLEN-1:0]            mprf2acc_rs1_data,
  output logic                       acc2mprf_w_req,
  output logic [MPRF_ADDR_WIDTH-1:0] acc2mprf_rd_addr,
  output logic [XLEN-1:0]            acc2mprf_rd_data
);

  localparam int AW = MPRF_ADDR_WIDTH;

  // Highest legal GPR index, one bit wider than the address so the
  // addr + cnt range check cannot wrap.
  localparam logic [AW:0] MAX_GPR = RVE_EN ? (AW+1)'(15) : (AW+1)'(31);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RSP,
    ST_ERR
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   cnt_q;
  logic [XLEN-1:0] rsp_data_q;
  logic            rsp_err_q;
  logic            rsp_last_q;
  logic            cmd_rdy_q;
  logic            rsp_vld_q;
  logic [AW-1:0]   rs1_addr_q;
  logic            w_req_q;
  logic [AW-1:0]   rd_addr_q;
  logic [XLEN-1:0] rd_data_q;

  logic [AW:0]     cmd_end;
  logic            cmd_illegal;

  // Legality of the command currently offered on the command channel.
  always_comb begin
    cmd_end     = {1'b0, dbg2acc_cmd_addr} + {1'b0, dbg2acc_cmd_cnt};
    cmd_illegal = ~hart_halted
                | (cmd_end > MAX_GPR)
                | (dbg2acc_cmd_we & (|dbg2acc_cmd_cnt));
  end

  // Access FSM; all outputs are registered and set up on the transition
  // into the state that owns them, so they are clean 0 everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_last_q <= 1'b0;
      cmd_rdy_q  <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rs1_addr_q <= '0;
      w_req_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dbg2acc_cmd_vld) begin
            cmd_rdy_q <= 1'b0;
            addr_q    <= dbg2acc_cmd_addr;
            cnt_q     <= dbg2acc_cmd_cnt;
            if (cmd_illegal) begin
              state <= ST_ERR;
            end else if (dbg2acc_cmd_we) begin
              state     <= ST_WRITE;
              w_req_q   <= (dbg2acc_cmd_addr != '0);
              rd_addr_q <= dbg2acc_cmd_addr;
              rd_data_q <= dbg2acc_cmd_wdata;
            end else begin
              state      <= ST_READ;
              rs1_addr_q <= dbg2acc_cmd_addr;
            end
          end
        end

        ST_ERR: begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
          rsp_last_q <= 1'b1;
          rsp_vld_q  <= 1'b1;
          state      <= ST_RSP;
        end

        ST_READ: begin
          // The read is still issued when the hart leaves halt; only the
          // data is discarded and the rest of the burst is dropped.
          if (!hart_halted) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            rsp_last_q <= 1'b1;
          end else begin
            rsp_data_q <= (addr_q == '0) ? '0 : mprf2acc_rs1_data;
            rsp_err_q  <= 1'b0;
            rsp_last_q <= (cnt_q == '0);
          end
          rs1_addr_q <= '0;
          rsp_vld_q  <= 1'b1;
          state      <= ST_RSP;
        end

        ST_WRITE: begin
          w_req_q    <= 1'b0;
          rd_addr_q  <= '0;
          rd_data_q  <= '0;
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b0;
          rsp_last_q <= 1'b1;
          rsp_vld_q  <= 1'b1;
          state      <= ST_RSP;
        end

        ST_RSP: begin
          if (dbg2acc_rsp_rdy) begin
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_last_q <= 1'b0;
            if (rsp_last_q) begin
              cmd_rdy_q <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              addr_q     <= addr_q + 1'b1;
              cnt_q      <= cnt_q - 1'b1;
              rs1_addr_q <= addr_q + 1'b1;
              state      <= ST_READ;
            end
          end
        end

        default: begin
          cmd_rdy_q <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign acc2dbg_cmd_rdy   = cmd_rdy_q;
  assign acc2dbg_rsp_vld   = rsp_vld_q;
  assign acc2dbg_rsp_data  = rsp_data_q;
  assign acc2dbg_rsp_err   = rsp_err_q;
  assign acc2dbg_rsp_last  = rsp_last_q;
  assign acc2mprf_rs1_addr = rs1_addr_q;
  assign acc2mprf_w_req    = w_req_q;
  assign acc2mprf_rd_addr  = rd_addr_q;
  assign acc2mprf_rd_data  = rd_data_q;

endmodule

// File: tb/tb_scr1_pipe_mprf_dbgacc.sv
// Directed bench for the debug MPRF accessor: a register-file model feeds
// the read port and absorbs writes; expected response beats are queued
// when a command is issued and popped as the accessor presents them.

module tb_scr1_pipe_mprf_dbgacc;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_vld, cmd_vld_e;
  logic        cmd_we;
  logic [4:0]  cmd_addr, cmd_cnt;
  logic [31:0] cmd_wdata;
  logic        rsp_rdy;
  logic        hart_halted;

  logic        cmd_rdy, rsp_vld, rsp_err, rsp_last, w_req;
  logic [31:0] rsp_data, rs1_data, rd_data;
  logic [4:0]  rs1_addr, rd_addr;

  logic        e_cmd_rdy, e_rsp_vld, e_rsp_err, e_rsp_last, e_w_req;
  logic [31:0] e_rsp_data, e_rs1_data, e_rd_data;
  logic [4:0]  e_rs1_addr, e_rd_addr;

  logic        sel_e;
  logic        s_rdy, s_vld, s_err, s_last;
  logic [31:0] s_data;

  logic [31:0] mem [32];
  int          w_cnt, r_cnt;
  logic [4:0]  last_w_addr;
  logic [31:0] last_w_data;

  rsp_t        exp_q[$];
  int          n_cmp, n_err;

  scr1_pipe_mprf_dbgacc #(.MPRF_ADDR_WIDTH(5), .XLEN(32), .RVE_EN(1'b0)) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dbg2acc_cmd_vld   (cmd_vld),
    .acc2dbg_cmd_rdy   (cmd_rdy),
    .dbg2acc_cmd_we    (cmd_we),
    .dbg2acc_cmd_addr  (cmd_addr),
    .dbg2acc_cmd_cnt   (cmd_cnt),
    .dbg2acc_cmd_wdata (cmd_wdata),
    .acc2dbg_rsp_vld   (rsp_vld),
    .dbg2acc_rsp_rdy   (rsp_rdy),
    .acc2dbg_rsp_data  (rsp_data),
    .acc2dbg_rsp_err   (rsp_err),
    .acc2dbg_rsp_last  (rsp_last),
    .hart_halted       (hart_halted),
    .acc2mprf_rs1_addr (rs1_addr),
    .mprf2acc_rs1_data (rs1_data),
    .acc2mprf_w_req    (w_req),
    .acc2mprf_rd_addr  (rd_addr),
    .acc2mprf_rd_data  (rd_data)
  );

  scr1_pipe_mprf_dbgacc #(.MPRF_ADDR_WIDTH(5), .XLEN(32), .RVE_EN(1'b1)) u_dut_e (
    .clk               (clk),
    .rst_n             (rst_n),
    .dbg2acc_cmd_vld   (cmd_vld_e),
    .acc2dbg_cmd_rdy   (e_cmd_rdy),
    .dbg2acc_cmd_we    (cmd_we),
    .dbg2acc_cmd_addr  (cmd_addr),
    .dbg2acc_cmd_cnt   (cmd_cnt),
    .dbg2acc_cmd_wdata (cmd_wdata),
    .acc2dbg_rsp_vld   (e_rsp_vld),
    .dbg2acc_rsp_rdy   (rsp_rdy),
    .acc2dbg_rsp_data  (e_rsp_data),
    .acc2dbg_rsp_err   (e_rsp_err),
    .acc2dbg_rsp_last  (e_rsp_last),
    .hart_halted       (hart_halted),
    .acc2mprf_rs1_addr (e_rs1_addr),
    .mprf2acc_rs1_data (e_rs1_data),
    .acc2mprf_w_req    (e_w_req),
    .acc2mprf_rd_addr  (e_rd_addr),
    .acc2mprf_rd_data  (e_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: combinational read, write on the clock edge.
  assign rs1_data   = mem[rs1_addr];
  assign e_rs1_data = mem[e_rs1_addr];

  always @(posedge clk) begin
    if (w_req)   mem[rd_addr]   <= rd_data;
    if (e_w_req) mem[e_rd_addr] <= e_rd_data;
  end

  // MPRF activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (w_req | e_w_req) begin
      w_cnt       <= w_cnt + 1;
      last_w_addr <= w_req ? rd_addr : e_rd_addr;
      last_w_data <= w_req ? rd_data : e_rd_data;
    end
    if ((rs1_addr != 5'd0) || (e_rs1_addr != 5'd0)) r_cnt <= r_cnt + 1;
  end

  assign s_rdy  = sel_e ? e_cmd_rdy  : cmd_rdy;
  assign s_vld  = sel_e ? e_rsp_vld  : rsp_vld;
  assign s_data = sel_e ? e_rsp_data : rsp_data;
  assign s_err  = sel_e ? e_rsp_err  : rsp_err;
  assign s_last = sel_e ? e_rsp_last : rsp_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] data, input logic err, input logic last);
    rsp_t r;
    r.data = data;
    r.err  = err;
    r.last = last;
    exp_q.push_back(r);
  endtask

  // Offers one command; returns one time unit after the accepting edge.
  task automatic send(input string tag, input logic we, input logic [4:0] addr,
                      input logic [4:0] cnt, input logic [31:0] wdata);
    @(negedge clk);
    check({tag, "_cmd_rdy"}, 64'(s_rdy), 64'd1);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_cnt   = cnt;
    cmd_wdata = wdata;
    if (sel_e) cmd_vld_e = 1'b1;
    else       cmd_vld   = 1'b1;
    @(posedge clk);
    #1;
    cmd_vld   = 1'b0;
    cmd_vld_e = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_cnt   = '0;
    cmd_wdata = '0;
  endtask

  // Waits (bounded) for a response beat, checks latency and contents,
  // optionally stalls, then completes the handshake.
  task automatic get_rsp(input string tag, input int exp_lat, input int stall);
    int   n;
    rsp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_vld && n < 8);
    check({tag, "_vld"}, 64'(s_vld), 64'd1);
    if (!s_vld) return;
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 64'(s_vld), 64'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_data"}, 64'(s_data), 64'(e.data));
    check({tag, "_err"},  64'(s_err),  64'(e.err));
    check({tag, "_last"}, 64'(s_last), 64'(e.last));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_vld"},  64'(s_vld),  64'd1);
      check({tag, "_stall_data"}, 64'(s_data), 64'(e.data));
      check({tag, "_stall_last"}, 64'(s_last), 64'(e.last));
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    rsp_rdy = 1'b0;
  endtask

  initial begin
    int w0, r0;
    logic [31:0] m9;
    n_cmp = 0;
    n_err = 0;
    w_cnt = 0;
    r_cnt = 0;
    last_w_addr = '0;
    last_w_data = '0;
    sel_e = 1'b0;
    rst_n = 1'b0;
    cmd_vld = 1'b0;
    cmd_vld_e = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_cnt = '0;
    cmd_wdata = '0;
    rsp_rdy = 1'b0;
    hart_halted = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    mem[0]  = 32'hFFFF_FFFF;
    mem[5]  = 32'hDEAD_BEEF;
    mem[29] = 32'd1;
    mem[30] = 32'd2;
    mem[31] = 32'd3;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_rdy",  64'(cmd_rdy),  64'd1);
    check("rst_rsp_vld",  64'(rsp_vld),  64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_w_req",    64'(w_req),    64'd0);
    check("rst_rs1_addr", 64'(rs1_addr), 64'd0);
    check("rst_rd_data",  64'(rd_data),  64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read of x5
    push_exp(32'hDEAD_BEEF, 1'b0, 1'b1);
    send("rd5", 1'b0, 5'd5, 5'd0, '0);
    @(negedge clk);
    check("rd5_rs1_addr", 64'(rs1_addr), 64'd5);
    get_rsp("rd5", 1, 0);

    // Three-beat read at the top of the file, stalled on beat 2
    push_exp(32'd1, 1'b0, 1'b0);
    push_exp(32'd2, 1'b0, 1'b0);
    push_exp(32'd3, 1'b0, 1'b1);
    send("rd29", 1'b0, 5'd29, 5'd2, '0);
    get_rsp("rd29_b1", 2, 0);
    get_rsp("rd29_b2", 2, 3);
    get_rsp("rd29_b3", 2, 0);

    // x0 reads as zero regardless of the file contents
    push_exp(32'd0, 1'b0, 1'b0);
    push_exp(mem[1], 1'b0, 1'b1);
    send("rd0", 1'b0, 5'd0, 5'd1, '0);
    get_rsp("rd0_b1", 2, 0);
    get_rsp("rd0_b2", 2, 0);

    // Write to x0: completes, no MPRF write
    w0 = w_cnt;
    push_exp(32'd0, 1'b0, 1'b1);
    send("wr0", 1'b1, 5'd0, 5'd0, 32'h1234);
    get_rsp("wr0", 2, 0);
    check("wr0_no_wreq", 64'(w_cnt), 64'(w0));

    // Write to x7: exactly one write strobe
    push_exp(32'd0, 1'b0, 1'b1);
    send("wr7", 1'b1, 5'd7, 5'd0, 32'h1234);
    get_rsp("wr7", 2, 0);
    check("wr7_wreq_cnt", 64'(w_cnt), 64'(w0 + 1));
    check("wr7_rd_addr",  64'(last_w_addr), 64'd7);
    check("wr7_rd_data",  64'(last_w_data), 64'h1234);
    check("wr7_mem",      64'(mem[7]), 64'h1234);
    push_exp(32'h1234, 1'b0, 1'b1);
    send("rd7", 1'b0, 5'd7, 5'd0, '0);
    get_rsp("rd7", 2, 0);

    // Illegal commands: error at T+2 with no MPRF activity
    w0 = w_cnt;
    r0 = r_cnt;
    push_exp(32'd0, 1'b1, 1'b1);
    send("wrcnt", 1'b1, 5'd3, 5'd1, 32'h55);
    get_rsp("wrcnt", 2, 0);
    push_exp(32'd0, 1'b1, 1'b1);
    send("rdrange", 1'b0, 5'd30, 5'd2, '0);
    get_rsp("rdrange", 2, 0);
    hart_halted = 1'b0;
    push_exp(32'd0, 1'b1, 1'b1);
    send("rdrun", 1'b0, 5'd4, 5'd0, '0);
    get_rsp("rdrun", 2, 0);
    push_exp(32'd0, 1'b1, 1'b1);
    send("wrrun", 1'b1, 5'd4, 5'd0, 32'h77);
    get_rsp("wrrun", 2, 0);
    hart_halted = 1'b1;
    sel_e = 1'b1;
    push_exp(32'd0, 1'b1, 1'b1);
    send("rve_rd14", 1'b0, 5'd14, 5'd2, '0);
    get_rsp("rve_rd14", 2, 0);
    check("illegal_no_w", 64'(w_cnt), 64'(w0));
    check("illegal_no_r", 64'(r_cnt), 64'(r0));

    // RVE instance: x14..x15 is still legal
    push_exp(mem[14], 1'b0, 1'b0);
    push_exp(mem[15], 1'b0, 1'b1);
    send("rve_ok", 1'b0, 5'd14, 5'd1, '0);
    get_rsp("rve_ok_b1", 2, 0);
    get_rsp("rve_ok_b2", 2, 0);
    sel_e = 1'b0;

    // Hart resumes mid-burst: beat 3 errors and terminates the burst
    push_exp(mem[1], 1'b0, 1'b0);
    push_exp(mem[2], 1'b0, 1'b0);
    push_exp(32'd0, 1'b1, 1'b1);
    send("burst", 1'b0, 5'd1, 5'd4, '0);
    get_rsp("burst_b1", 2, 0);
    get_rsp("burst_b2", 2, 0);
    hart_halted = 1'b0;
    @(negedge clk);
    check("burst_b3_rs1", 64'(rs1_addr), 64'd3);
    get_rsp("burst_b3", 1, 0);
    @(negedge clk);
    check("burst_idle_rdy", 64'(cmd_rdy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("burst_no_more", 64'(rsp_vld), 64'd0);
    end
    hart_halted = 1'b1;

    // Reset during WRITE aborts the write and the response
    m9 = mem[9];
    send("wrrst", 1'b1, 5'd9, 5'd0, 32'h5555_AAAA);
    @(negedge clk);
    check("wrrst_wreq_on", 64'(w_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("wrrst_wreq_off", 64'(w_req), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("wrrst_cmd_rdy", 64'(cmd_rdy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrrst_no_rsp", 64'(rsp_vld), 64'd0);
    end
    check("wrrst_mem", 64'(mem[9]), 64'(m9));
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scr1_pipe_mprf_dbgacc.md
SCR1_PIPE_MPRF_DBGACC -- requirements
Module: scr1_pipe_mprf_dbgacc

Interface
REQ-001 SHALL have parameter MPRF_ADDR_WIDTH, default 5, GPR address width.
REQ-002 SHALL have parameter XLEN, default 32, GPR data width.
REQ-003 SHALL have parameter RVE_EN, default 0; 1 limits the highest legal GPR to x15, otherwise x31.
REQ-004 SHALL have ports, in this order:
- clk  in  1  core clock
- rst_n  in  1  reset, active-low
- dbg2acc_cmd_vld  in  1  command valid
- acc2dbg_cmd_rdy  out  1  command ready
- dbg2acc_cmd_we  in  1  1 = write, 0 = read
- dbg2acc_cmd_addr  in  MPRF_ADDR_WIDTH  first GPR
- dbg2acc_cmd_cnt  in  MPRF_ADDR_WIDTH  GPR count minus 1; reads only
- dbg2acc_cmd_wdata  in  XLEN  write data
- acc2dbg_rsp_vld  out  1  response valid
- dbg2acc_rsp_rdy  in  1  response ready
- acc2dbg_rsp_data  out  XLEN  read data
- acc2dbg_rsp_err  out  1  access error
- acc2dbg_rsp_last  out  1  final beat of the command
- hart_halted  in  1  hart is in debug halt
- acc2mprf_rs1_addr  out  MPRF_ADDR_WIDTH  MPRF read address
- mprf2acc_rs1_data  in  XLEN  MPRF read data, combinational from address
- acc2mprf_w_req  out  1  MPRF write request
- acc2mprf_rd_addr  out  MPRF_ADDR_WIDTH  MPRF write address
- acc2mprf_rd_data  out  XLEN  MPRF write data
REQ-005 SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-006 SHALL implement a FSM with states IDLE, READ, WRITE, RSP, ERR.
REQ-007 acc2dbg_cmd_rdy SHALL equal 1 only in IDLE; a command SHALL be accepted on cmd_vld & cmd_rdy.
REQ-008 On accept, a command SHALL be illegal if any of the following holds:
- hart_halted = 0;
- addr + cnt exceeds the highest legal GPR (sum computed MPRF_ADDR_WIDTH+1 bits wide, no wrap);
- we = 1 with cnt != 0.
An illegal command SHALL go to ERR; a legal read to READ; a legal write to WRITE.
REQ-009 ERR SHALL last one cycle, then RSP with err = 1, last = 1, data = 0; the MPRF SHALL NOT be accessed.
REQ-010 READ SHALL last exactly one cycle:
- drives acc2mprf_rs1_addr = current address;
- captures mprf2acc_rs1_data into the response register at cycle end;
- then goes to RSP.
REQ-011 WRITE SHALL last exactly one cycle:
- drives acc2mprf_rd_addr / acc2mprf_rd_data from the latched command;
- asserts acc2mprf_w_req only if the address != 0 (a write to x0 completes without error and without a write);
- then goes to RSP with err = 0, data = 0, last = 1.
REQ-012 In RSP, acc2dbg_rsp_vld SHALL be 1 and response fields SHALL stay stable until rsp_rdy.
REQ-013 On rsp_vld & rsp_rdy:
- if last = 1, go to IDLE;
- otherwise, increment the current address by 1 and decrement the remaining count, then go to READ.
REQ-014 A read of x0 SHALL return 0.
REQ-015 rsp_last SHALL be 1 on the beat whose remaining count is 0.
REQ-016 If hart_halted = 0 during a READ cycle:
- the MPRF read SHALL still be performed with its data discarded;
- that beat SHALL respond with err = 1, data = 0, last = 1;
- the remaining beats SHALL be dropped.
REQ-017 Outside READ, acc2mprf_rs1_addr SHALL be 0; outside WRITE, acc2mprf_w_req, acc2mprf_rd_addr and acc2mprf_rd_data SHALL be 0.
REQ-018 Latency SHALL be: accept at cycle T, rsp_vld at T+2 for every command type; each further read beat SHALL appear 2 cycles after the previous handshake.
REQ-019 acc2mprf_w_req SHALL NOT be asserted more than once per write command.

Reset
REQ-020 While rst_n = 0:
- the FSM SHALL be in IDLE;
- all outputs SHALL be 0 except acc2dbg_cmd_rdy, which SHALL be 1 once in IDLE;
- the address, count and response registers SHALL be 0.
REQ-021 An rst_n assertion in any state SHALL abort the command immediately with no further MPRF write and no response.

Verification
REQ-022 Halted, read addr = 5, cnt = 0, MPRF x5 = 0xDEADBEEF -> rs1_addr = 5 at T+1; rsp_vld at T+2 with data 0xDEADBEEF, err 0, last 1.
REQ-023 Halted, read addr = 29, cnt = 2, x29..x31 = 1,2,3, rsp_rdy held low 3 cycles on beat 2 -> three beats with data 1,2,3; last only on the third; data stable while stalled.
REQ-024 Halted, write addr = 0 with data 0x1234 -> w_req stays 0; response err 0. Write addr = 7 with data 0x1234 -> w_req = 1 for one cycle with rd_addr 7, rd_data 0x1234.
REQ-025 Each of the following SHALL give a response at T+2 with err 1 and no MPRF activity:
- RVE_EN = 1, read addr = 14, cnt = 2;
- write with cnt = 1;
- any command with hart_halted = 0.
REQ-026 Read burst addr = 1, cnt = 4, with hart_halted dropped before beat 3's READ cycle -> beats 1 and 2 good; beat 3 err 1, last 1; then IDLE.
REQ-027 rst_n asserted during WRITE -> w_req = 0 immediately; after release, cmd_rdy = 1 and no response is issued.
